// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the output-mux select arbiters.
package mux_arb_pkg;

  localparam int unsigned REQ_N = 2;

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    GAP
  } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: favours the requester that did not win last time.
module rr_pick2
  import mux_arb_pkg::*;
(
  input  logic [REQ_N-1:0] req,
  input  logic             last,
  output logic             any,
  output logic             idx
);

  always_comb begin
    any = |req;
    idx = (req == 2'b11) ? ~last : req[1];
  end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin owner of the 2:1 output mux select, with a hold cap and a
// break-before-make gap cycle on every ownership change.
module mux_sel_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 8,
  parameter int unsigned CW       = $clog2(HOLD_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [REQ_N-1:0] req,
  output logic [REQ_N-1:0] gnt,
  output logic             sel,
  output logic             valid,
  output logic [CW-1:0]    hold_cnt
);

  localparam logic [CW-1:0] HoldMax = CW'(HOLD_MAX);

  arb_state_t state;
  logic       last;
  logic       pick_any;
  logic       pick_idx;
  logic       other;
  logic       at_cap;
  logic       release_now;

  rr_pick2 u_pick (
    .req  (req),
    .last (last),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  always_comb begin
    other       = ~sel;
    at_cap      = (hold_cnt == HoldMax);
    release_now = !req[sel] || (at_cap && req[other]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      sel      <= 1'b0;
      valid    <= 1'b0;
      hold_cnt <= '0;
      last     <= 1'b1;
    end else if (ena) begin
      unique case (state)
        IDLE, GAP: begin
          if (pick_any) begin
            state    <= OWN;
            gnt      <= pick_idx ? 2'b10 : 2'b01;
            sel      <= pick_idx;
            last     <= pick_idx;
            valid    <= 1'b1;
            hold_cnt <= CW'(1);
          end else begin
            state    <= IDLE;
            gnt      <= '0;
            valid    <= 1'b0;
            hold_cnt <= '0;
          end
        end
        OWN: begin
          if (release_now) begin
            // sel is left alone so the mux never flips while valid is high
            state    <= (|req) ? GAP : IDLE;
            gnt      <= '0;
            valid    <= 1'b0;
            hold_cnt <= '0;
          end else if (!at_cap) begin
            hold_cnt <= hold_cnt + CW'(1);
          end
        end
        default: begin
          state    <= IDLE;
          gnt      <= '0;
          valid    <= 1'b0;
          hold_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/mux_sel_arbiter.md
# mux_sel_arbiter

Two-requester round-robin arbiter that owns the select line of the project's 2:1 output mux and decides which source drives it. It grants the mux to one requester at a time and caps each tenure at `HOLD_MAX` cycles when the other side is waiting. It inserts one break-before-make gap cycle on every ownership change, so downstream never sees a select flip while output is flagged valid. It sits between the requesting logic and the mux, inside the `tt_um_` top.

## Interface
- `HOLD_MAX`, default 8: maximum consecutive grant cycles while the other requester waits; legal range 1..255.
- `CW`, default `$clog2(HOLD_MAX+1)`: hold counter width; derived, not overridden.

Ports:
- `clk` input, 1 bit: sole clock, rising edge.
- `rst` input, 1 bit: synchronous, active-high reset; has priority over `ena`.
- `ena` input, 1 bit: when 0, all state and outputs hold.
- `req` input, 2 bits: `req[i]` is a level request from requester i.
- `gnt` output, 2 bits: registered one-hot grant, or 00.
- `sel` output, 1 bit: registered mux select; 0 selects source 0.
- `valid` output, 1 bit: registered; equals `|gnt`. Mux output is meaningful only when this is 1.
- `hold_cnt` output, `CW` bits: cycles the current owner has held the grant.

## Operation
- States: IDLE (no owner), OWN (owner `o` = `sel`), GAP (one dead cycle after a release).
- `last` register: index of the most recent owner. It steers the round-robin pick.
- Pick rule (IDLE and GAP): if both requests are high, grant `~last`. If one is high, grant that one. If none is high, go to IDLE.
- On grant of requester i:
  - `gnt` becomes one-hot i.
  - `sel` becomes i.
  - `last` becomes i.
  - `hold_cnt` becomes 1.
  - State becomes OWN.
- OWN, each cycle:
  - `req[o]` = 0: release.
  - `hold_cnt == HOLD_MAX` and `req[~o]` = 1: release (pre-emption).
  - `hold_cnt == HOLD_MAX` and `req[~o]` = 0: keep the grant; `hold_cnt` saturates at `HOLD_MAX`.
  - Otherwise: keep the grant; `hold_cnt` increments.
- Release:
  - If any request is pending, go to GAP: `gnt` = 00, `valid` = 0, `sel` unchanged, `hold_cnt` = 0.
  - If no request is pending, go straight to IDLE, with the same output values.
- GAP lasts exactly 1 cycle. The pick rule is evaluated in GAP, so the new grant is visible on the following cycle.
- `sel` changes only on the edge where `gnt` goes from 00 to one-hot. It never changes while `valid` = 1.
- Reset values:
  - State: IDLE.
  - `gnt` = 00, `sel` = 0, `valid` = 0, `hold_cnt` = 0.
  - `last` = 1, so requester 0 wins the first tie.
- Reset mid-tenure: the grant drops on the next edge. No GAP cycle is inserted.
- `ena` = 0 freezes state, `last`, the counter and all outputs. Requests are not sampled while frozen.

## Timing
- Request-to-grant latency:
  - From IDLE: `req` sampled at edge N, `gnt` and `valid` high after edge N.
  - Switchover: owner drops `req` at edge N, GAP after edge N, new `gnt` after edge N+1.
- Pre-emption: the owner holds exactly `HOLD_MAX` cycles, then there is 1 GAP cycle, then the other requester is granted.
- All outputs are registered. There is no combinational path from `req` to any output.

## Structure
- Shared package `mux_arb_pkg`:
  - State enum `arb_state_t` {IDLE, OWN, GAP}.
  - Constant `REQ_N = 2`.
- Sub-module `rr_pick2`: combinational. Inputs `req[1:0]` and `last`. Outputs `any` and `idx`. Reused by later arbiters.
- Top level holds the FSM, `last`, the hold counter and the output registers.

## Test plan
All scenarios use `HOLD_MAX` = 4.
- Reset: hold `rst` = 1 for 2 cycles with `req` = 11. Response: `gnt` = 00, `sel` = 0, `valid` = 0, `hold_cnt` = 0. On the first edge after release, `gnt` = 01.
- Single requester: `req` = 10 held for 10 cycles. Response: `gnt` = 10 from cycle 1, `sel` = 1, `hold_cnt` goes 1,2,3,4,4,4… with no GAP.
- Contention: `req` = 11 continuously from reset. Response:
  - `gnt` = 01 for 4 cycles, then 00 for 1 cycle, then 10 for 4 cycles, then 00, then 01.
  - `sel` toggles only during the 00 cycles.
- Voluntary release: requester 0 owns the grant and drops `req[0]` at `hold_cnt` = 2 while `req[1]` = 1. Response: one GAP cycle, then `gnt` = 10, `hold_cnt` = 1.
- `ena` freeze: set `ena` = 0 for 3 cycles mid-tenure at `hold_cnt` = 2, while toggling `req`. Response: all outputs constant. After `ena` returns to 1, counting resumes at 3.
- Reset mid-GAP: assert `rst` on the GAP cycle with `req` = 11. Response: IDLE values. After `rst` deasserts, the first grant is `gnt` = 01, because `last` was reset.
